// File: rtl/falafel_lsu.sv
// Free-list header load/store unit: walks allocator headers in memory and
// guards the free list with a spin lock word, one operation at a time.

package falafel_lsu_pkg;

    localparam int unsigned DATA_W = 64;

    typedef logic [2:0] lsu_op_t;

    localparam lsu_op_t LsuLoad   = 3'd0;
    localparam lsu_op_t LsuInsert = 3'd1;
    localparam lsu_op_t LsuDelete = 3'd2;
    localparam lsu_op_t LsuLock   = 3'd3;
    localparam lsu_op_t LsuUnlock = 3'd4;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] size;
        logic [DATA_W-1:0] next_addr;
    } header_data_t;

    typedef struct packed {
        header_data_t header_data;
        lsu_op_t      lsu_op;
        logic         val;
    } header_data_req_t;

    typedef struct packed {
        header_data_t header_data;
        logic         val;
    } header_data_rsp_t;

endpackage

module falafel_lsu
    import falafel_lsu_pkg::*;
#(
    parameter logic [DATA_W-1:0] LOCK_ADDR      = '0,
    parameter logic [DATA_W-1:0] NEXT_OFFSET    = DATA_W'(DATA_W / 8),
    parameter int unsigned       BACKOFF_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  header_data_req_t  req_from_core_i,
    output logic              lsu_ready_o,
    output header_data_rsp_t  rsp_to_core_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned     CntW    = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(BACKOFF_CYCLES - 1);

    localparam logic [3:0] StIdle        = 4'd0;
    localparam logic [3:0] StLockRd      = 4'd1;
    localparam logic [3:0] StLockBackoff = 4'd2;
    localparam logic [3:0] StLockWr      = 4'd3;
    localparam logic [3:0] StUnlockWr    = 4'd4;
    localparam logic [3:0] StRdSize      = 4'd5;
    localparam logic [3:0] StRdNext      = 4'd6;
    localparam logic [3:0] StWrSize      = 4'd7;
    localparam logic [3:0] StWrNext      = 4'd8;
    localparam logic [3:0] StWrPtr       = 4'd9;
    localparam logic [3:0] StRsp         = 4'd10;

    logic [3:0]        state_q, state_d;
    logic              rd_pend_q, rd_pend_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    header_data_t      hdr_q, hdr_d;
    lsu_op_t           op_q, op_d;
    logic [DATA_W-1:0] size_q, size_d;
    logic [DATA_W-1:0] next_q, next_d;

    logic              bus_req, bus_we;
    logic [DATA_W-1:0] bus_addr, bus_wdata;
    logic [DATA_W-1:0] next_ptr;
    logic              rd_state, rd_done;
    header_data_t      load_hdr;

    // Wraps modulo 2^DATA_W by construction.
    assign next_ptr = hdr_q.addr + NEXT_OFFSET;

    assign rd_state = (state_q == StLockRd) || (state_q == StRdSize) || (state_q == StRdNext);
    // rd_pend_q marks a granted read; rvalid outside that window is dropped.
    assign rd_done  = rd_state && rd_pend_q && mem_rvalid_i;

    always_comb begin
        state_d   = state_q;
        rd_pend_d = rd_pend_q;
        cnt_d     = cnt_q;
        hdr_d     = hdr_q;
        op_d      = op_q;
        size_d    = size_q;
        next_d    = next_q;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;

        if (rd_state) begin
            if (!rd_pend_q && mem_gnt_i) begin
                rd_pend_d = 1'b1;
            end else if (rd_done) begin
                rd_pend_d = 1'b0;
            end
        end

        case (state_q)
            StIdle: begin
                if (req_from_core_i.val) begin
                    hdr_d  = req_from_core_i.header_data;
                    op_d   = req_from_core_i.lsu_op;
                    size_d = '0;
                    next_d = '0;
                    case (req_from_core_i.lsu_op)
                        LsuLoad:   state_d = StRdSize;
                        LsuInsert: state_d = StWrSize;
                        LsuDelete: state_d = StWrPtr;
                        LsuLock:   state_d = StLockRd;
                        LsuUnlock: state_d = StUnlockWr;
                        default:   state_d = StRsp;
                    endcase
                end
            end
            StLockRd: begin
                bus_req  = !rd_pend_q;
                bus_addr = LOCK_ADDR;
                if (rd_done) begin
                    if (mem_rdata_i != '0) begin
                        state_d = StLockBackoff;
                        cnt_d   = CntLoad;
                    end else begin
                        state_d = StLockWr;
                    end
                end
            end
            StLockBackoff: begin
                if (cnt_q == '0) begin
                    state_d = StLockRd;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StLockWr: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = LOCK_ADDR;
                bus_wdata = DATA_W'(1);
                if (mem_gnt_i) state_d = StRsp;
            end
            StUnlockWr: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = LOCK_ADDR;
                if (mem_gnt_i) state_d = StRsp;
            end
            StRdSize: begin
                bus_req  = !rd_pend_q;
                bus_addr = hdr_q.addr;
                if (rd_done) begin
                    size_d  = mem_rdata_i;
                    state_d = StRdNext;
                end
            end
            StRdNext: begin
                bus_req  = !rd_pend_q;
                bus_addr = next_ptr;
                if (rd_done) begin
                    next_d  = mem_rdata_i;
                    state_d = StRsp;
                end
            end
            StWrSize: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = hdr_q.addr;
                bus_wdata = hdr_q.size;
                if (mem_gnt_i) state_d = StWrNext;
            end
            StWrNext, StWrPtr: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = next_ptr;
                bus_wdata = hdr_q.next_addr;
                if (mem_gnt_i) state_d = StRsp;
            end
            StRsp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            rd_pend_q <= 1'b0;
            cnt_q     <= '0;
            hdr_q     <= '0;
            op_q      <= '0;
            size_q    <= '0;
            next_q    <= '0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
            cnt_q     <= cnt_d;
            hdr_q     <= hdr_d;
            op_q      <= op_d;
            size_q    <= size_d;
            next_q    <= next_d;
        end
    end

    // Bus fields are forced to zero whenever no request is presented.
    assign mem_req_o   = bus_req;
    assign mem_we_o    = bus_req & bus_we;
    assign mem_addr_o  = bus_req ? bus_addr : '0;
    assign mem_wdata_o = bus_req ? bus_wdata : '0;

    // Gated by rst_ni so ready is low for the whole reset, not just after an edge.
    assign lsu_ready_o = rst_ni && (state_q == StIdle);

    always_comb begin
        load_hdr.addr      = hdr_q.addr;
        load_hdr.size      = size_q;
        load_hdr.next_addr = next_q;
    end

    always_comb begin
        rsp_to_core_o = '0;
        if (state_q == StRsp) begin
            rsp_to_core_o.val         = 1'b1;
            rsp_to_core_o.header_data = (op_q == LsuLoad) ? load_hdr : hdr_q;
        end
    end

endmodule
